// File: rtl/bram_port_client_if.sv
// Request/response handshake bundle between a requester and bram_port_client.
// master = requester side, slave = the adapter.
interface bram_port_client_if #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [data_width-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bram_port_client.sv
// Initiator adapter for one block-RAM port: issues requests with zero added latency
// and hides the RAM's one-cycle read latency behind a credited response FIFO.
module bram_port_client #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int resp_depth = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bram_port_client_if.slave           bus,
  output logic                        bram_en,
  output logic                        bram_write_en,
  output logic [addr_width-1:0]       bram_addr,
  output logic [data_width-1:0]       bram_write_data,
  input  logic [data_width-1:0]       bram_read_data,
  output logic [$clog2(resp_depth):0] resp_count
);
  localparam int ptr_w   = $clog2(resp_depth);
  localparam int count_w = ptr_w + 1;
  localparam logic [count_w-1:0] depth_c = count_w'(resp_depth);

  logic                  active_q, active_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [ptr_w-1:0]      head_q, head_d;
  logic [ptr_w-1:0]      tail_q, tail_d;
  logic [count_w-1:0]    fifo_count_q, fifo_count_d;
  logic [data_width-1:0] fifo_mem_q [resp_depth];

  logic fire;
  logic rd_fire;
  logic push;
  logic pop;

  // Credits cover the in-flight read too, so a capture can never meet a full FIFO.
  assign resp_count    = fifo_count_q + count_w'(rd_inflight_q);
  assign bus.req_ready = active_q & (resp_count < depth_c);
  assign fire          = bus.req_valid & bus.req_ready;
  assign rd_fire       = fire & ~bus.req_write;

  assign bram_en         = fire;
  assign bram_write_en   = fire & bus.req_write;
  assign bram_addr       = bus.req_addr;
  assign bram_write_data = bus.req_data;

  assign push           = rd_inflight_q;
  assign bus.resp_valid = (fifo_count_q != '0);
  assign pop            = bus.resp_valid & bus.resp_ready;
  assign bus.resp_data  = fifo_mem_q[head_q];

  always_comb begin
    active_d      = 1'b1;
    rd_inflight_d = rd_fire;
    head_d        = head_q;
    tail_d        = tail_q;
    fifo_count_d  = fifo_count_q;
    if (push) begin
      tail_d = tail_q + ptr_w'(1);
    end
    if (pop) begin
      head_d = head_q + ptr_w'(1);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + count_w'(1);
      2'b01:   fifo_count_d = fifo_count_q - count_w'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      rd_inflight_q <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      fifo_count_q  <= '0;
    end else begin
      active_q      <= active_d;
      rd_inflight_q <= rd_inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fifo_count_q  <= fifo_count_d;
    end
  end

  // RAM read data is only meaningful the cycle after a read was issued.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[tail_q] <= bram_read_data;
    end
  end
endmodule

// File: tb/tb_bram_port_client.sv
// Self-checking bench: behavioural RAM, transaction-level reference model and
// directed plus randomized scenarios for bram_port_client.
module tb_bram_port_client;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bram_en;
  logic          bram_write_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_write_data;
  logic [DW-1:0] bram_read_data;
  logic [2:0]    resp_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bram_port_client_if #(.addr_width(AW), .data_width(DW)) bus_if ();

  bram_port_client #(.addr_width(AW), .data_width(DW), .resp_depth(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .bram_en         (bram_en),
    .bram_write_en   (bram_write_en),
    .bram_addr       (bram_addr),
    .bram_write_data (bram_write_data),
    .bram_read_data  (bram_read_data),
    .resp_count      (resp_count)
  );

  always #5 clk = ~clk;

  // Behavioural RAM port: registered read, holds its output when not enabled.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_write_en) ram[bram_addr] <= bram_write_data;
      else               bram_read_data <= ram[bram_addr];
    end
  end

  // Reference model: memory image plus ordered queue of outstanding read results.
  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [1024];

  always @(negedge clk) begin
    logic fire_now;
    logic exp_valid;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      checks++;
      if (bram_en !== 1'b0 || bus_if.req_ready !== 1'b0 || resp_count !== 3'd0 || bus_if.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: en=%b ready=%b count=%0d valid=%b, required 0 0 0 0",
                 bram_en, bus_if.req_ready, resp_count, bus_if.resp_valid);
      end
    end else begin
      fire_now  = bus_if.req_valid & bus_if.req_ready;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].stamp + 2 <= cyc);
      checks++;
      if (int'(resp_count) !== exp_q.size() || int'(resp_count) > DEPTH) begin
        errors++;
        $display("FAIL resp_count: got %0d, required %0d (max %0d)", resp_count, exp_q.size(), DEPTH);
      end
      checks++;
      if (exp_q.size() >= DEPTH && bus_if.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL credit: req_ready=%b with %0d outstanding, required 0", bus_if.req_ready, exp_q.size());
      end
      checks++;
      if (bus_if.resp_valid !== exp_valid) begin
        errors++;
        $display("FAIL resp_valid: got %b, required %b", bus_if.resp_valid, exp_valid);
      end
      checks++;
      if (bram_en !== fire_now || bram_write_en !== (fire_now & bus_if.req_write) || bram_addr !== bus_if.req_addr) begin
        errors++;
        $display("FAIL bram_drive: en=%b we=%b addr=%h, required %b %b %h",
                 bram_en, bram_write_en, bram_addr, fire_now, fire_now & bus_if.req_write, bus_if.req_addr);
      end
      if (fire_now && bus_if.req_write) begin
        checks++;
        if (bram_write_data !== bus_if.req_data) begin
          errors++;
          $display("FAIL bram_wdata: got %h, required %h", bram_write_data, bus_if.req_data);
        end
      end
      if (bus_if.resp_valid === 1'b1 && bus_if.resp_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got %h, required no response", bus_if.resp_data);
        end else begin
          if (bus_if.resp_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL resp_data: got %h, required %h", bus_if.resp_data, exp_q[0].data);
          end else begin
            $display("resp  cyc=%0d data=%h", cyc, bus_if.resp_data);
          end
          void'(exp_q.pop_front());
        end
      end
      if (fire_now) begin
        if (bus_if.req_write) begin
          model_mem[bus_if.req_addr] = bus_if.req_data;
          $display("write cyc=%0d addr=%h data=%h", cyc, bus_if.req_addr, bus_if.req_data);
        end else begin
          exp_q.push_back('{data: model_mem[bus_if.req_addr], stamp: cyc});
          $display("read  cyc=%0d addr=%h", cyc, bus_if.req_addr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.req_valid = v;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 10'h005, '0);
    repeat (2) @(negedge clk);
    checks++;
    if (bram_en !== 1'b0 || bus_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%b ready=%b, required 0 0", bram_en, bus_if.req_ready);
    end
    step();
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, '0, '0);
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (bus_if.req_ready !== 1'b1 || resp_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b count=%0d, required 1 0", bus_if.req_ready, resp_count);
    end
  endtask

  task automatic test_preload();
    logic [DW-1:0] d;
    for (int a = 0; a < 16; a++) begin
      step();
      d = (a >= 1 && a <= 4) ? DW'(a * 32'h11) : $urandom;
      set_req(1'b1, 1'b1, AW'(a), d);
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL preload_ready: got %b, required 1", bus_if.req_ready);
      end
    end
    step();
    set_req(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_write_read();
    bus_if.resp_ready = 1'b0;
    step();
    set_req(1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bram_en !== 1'b1 || bram_write_en !== 1'b1) begin
      errors++;
      $display("FAIL wr_cycle: en=%b we=%b, required 1 1", bram_en, bram_write_en);
    end
    step();
    set_req(1'b1, 1'b0, 10'h005, '0);
    @(negedge clk);
    checks++;
    if (bram_en !== 1'b1 || bram_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rd_cycle: en=%b we=%b, required 1 0", bram_en, bram_write_en);
    end
    step();
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus_if.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_early: resp_valid=%b, required 0", bus_if.resp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_data: valid=%b data=%h, required 1 deadbeef", bus_if.resp_valid, bus_if.resp_data);
    end
    step();
    bus_if.resp_ready = 1'b1;
    step();
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus_if.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 4) set_req(1'b1, 1'b0, AW'(c + 1), '0);
      else       set_req(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if (bus_if.req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready: cycle %0d got %b, required 1", c, bus_if.req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (bus_if.resp_valid !== 1'b1 || bus_if.resp_data !== DW'((c - 1) * 32'h11)) begin
          errors++;
          $display("FAIL b2b_resp: valid=%b data=%h, required 1 %h",
                   bus_if.resp_valid, bus_if.resp_data, DW'((c - 1) * 32'h11));
        end
      end
    end
    step();
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic test_stall();
    int accepts = 0;
    bus_if.resp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      set_req(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
      @(negedge clk);
      if (bus_if.req_ready === 1'b1) accepts++;
    end
    step();
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (accepts != DEPTH || resp_count !== 3'd4 || bus_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall: accepts=%0d count=%0d ready=%b, required 4 4 0", accepts, resp_count, bus_if.req_ready);
    end
    step();
    bus_if.resp_ready = 1'b1;
    step();
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready !== 1'b1 || resp_count !== 3'd3) begin
      errors++;
      $display("FAIL stall_pop: ready=%b count=%0d, required 1 3", bus_if.req_ready, resp_count);
    end
    bus_if.resp_ready = 1'b1;
    repeat (4) step();
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_count !== 3'd0) begin
      errors++;
      $display("FAIL stall_drain: count=%0d, required 0", resp_count);
    end
  endtask

  task automatic test_wrap_steady();
    bus_if.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) set_req(1'b0, 1'b0, '0, '0);
      else        set_req(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
    end
    step();
    @(negedge clk);
    checks++;
    if (resp_count !== 3'd2 || bus_if.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_fill: count=%0d valid=%b, required 2 1", resp_count, bus_if.resp_valid);
    end
    step();
    set_req(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
    for (int i = 0; i < 12; i++) begin
      step();
      set_req(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
      bus_if.resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_count !== 3'd3 || bus_if.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_steady: iter %0d count=%0d valid=%b, required 3 1", i, resp_count, bus_if.resp_valid);
      end
    end
    step();
    set_req(1'b0, 1'b0, '0, '0);
    repeat (5) step();
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    d = $urandom;
    bus_if.resp_ready = 1'b1;
    step();
    set_req(1'b1, 1'b1, 10'h007, d);
    step();
    set_req(1'b1, 1'b0, 10'h007, '0);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.resp_valid !== 1'b0 || resp_count !== 3'd0) begin
        errors++;
        $display("FAIL reset_mid_discard: valid=%b count=%0d, required 0 0", bus_if.resp_valid, resp_count);
      end
      step();
    end
    set_req(1'b1, 1'b0, 10'h007, '0);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    step();
    @(negedge clk);
    checks++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_data !== d) begin
      errors++;
      $display("FAIL reset_mid_reread: valid=%b data=%h, required 1 %h", bus_if.resp_valid, bus_if.resp_data, d);
    end
    step();
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step();
      set_req(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), $urandom);
      bus_if.resp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    set_req(1'b0, 1'b0, '0, '0);
    bus_if.resp_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    checks++;
    if (resp_count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: count=%0d outstanding=%0d, required 0 0", resp_count, exp_q.size());
    end
    step();
    bus_if.resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.resp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    test_reset();
    test_preload();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_wrap_steady();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_port_client.md
Name: bram_port_client

Overview:
- Initiator-side adapter for one port of the team's true-dual-port block RAM.
- Accepts read/write requests over a valid/ready interface and drives the RAM port signals (en, addr, write_en, write_data).
- Captures the RAM's registered read data exactly one cycle after each read is issued, then buffers it in a response FIFO with valid/ready back-pressure.
- Lets Bluespec-side logic use the RAM without tracking its one-cycle read latency.

Parameters:
- addr_width, 10, RAM address width; must match the RAM instance.
- data_width, 32, RAM data width; must match the RAM instance.
- resp_depth, 4, response FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; same clock as the attached RAM port.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  addr_width  request address.
- req_data  input  data_width  write data; ignored for reads.
- resp_valid  output  1  read response available at FIFO head.
- resp_ready  input  1  consumer takes the head entry.
- resp_data  output  data_width  read data at FIFO head.
- bram_en  output  1  to RAM port en.
- bram_write_en  output  1  to RAM port write_en.
- bram_addr  output  addr_width  to RAM port addr.
- bram_write_data  output  data_width  to RAM port write_data.
- bram_read_data  input  data_width  from RAM port read_data (registered in RAM, valid cycle after en).
- resp_count  output  $clog2(resp_depth)+1  entries in FIFO plus reads in flight.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, resp_valid=0, resp_count=0; FIFO pointers and in-flight flag cleared.
  - bram_en=0 and bram_write_en=0 while rst_n low.
- Accept: fire = req_valid & req_ready.
  - req_ready = (resp_count < resp_depth), from registered state only.
  - Writes use the same rule, so no combinational path exists from resp_ready or req_write to req_ready.
- RAM drive (combinational, zero added latency):
  - bram_en = fire; bram_write_en = fire & req_write.
  - bram_addr = req_addr; bram_write_data = req_data.
  - When not firing, bram_en=0; addr and data are don't-care but pass through.
- Read tracking: rd_inflight register set on a read fire and cleared otherwise. At most one read is in flight, because RAM latency is exactly 1.
- Capture: when rd_inflight=1, bram_read_data is written into the FIFO tail on that edge. Never sample bram_read_data on any other cycle; the RAM holds stale data when en is low.
- Latency: a read accepted in cycle N has resp_valid=1 in cycle N+2 if the FIFO was empty.
- FIFO: circular, head/tail pointers wrap at resp_depth.
  - resp_valid = (fifo_count != 0); resp_data = head entry.
  - Pop on resp_valid & resp_ready.
  - Simultaneous capture and pop: count unchanged, both pointers advance.
- resp_count = fifo_count + rd_inflight. Update: +1 on read fire, -1 on pop, both → unchanged. Writes do not change it.
  - The credit rule guarantees a capture never finds the FIFO full; the bench asserts this.
- Ordering:
  - Responses return in request order.
  - Write then read to the same address in consecutive cycles returns the new data, since the RAM write completes at the first edge.
  - Only one op per cycle is issued, so the RAM's same-cycle read-during-write case never arises.
- Throughput: with resp_ready held high and resp_depth ≥ 4, one read per cycle is sustained. With resp_depth=2, the rate is 2 reads per 3 cycles.
- Reset mid-operation: in-flight read and FIFO contents are discarded, and no response is produced for them. RAM contents are untouched by this block.
- The RAM's own rst_n on this port is tied high by the integrator; this block never resets the RAM.

Test Plan:
- Reset with req_valid=1 → bram_en=0, req_ready=0; after release, req_ready=1 and resp_count=0.
- Write addr 0x005 data 0xDEADBEEF in cycle N, read 0x005 in N+1 → bram_en=1 in both cycles, bram_write_en=1 only in N; resp_valid=1 in N+3 with resp_data=0xDEADBEEF.
- Four back-to-back reads of addr 1..4 preloaded 0x11..0x44, resp_ready=1, resp_depth=4 → req_ready stays 1; responses 0x11,0x22,0x33,0x44 on consecutive cycles in order.
- resp_ready=0, issue reads until stall → req_ready drops after 4 accepts, resp_count=4, no FIFO overflow. Raise resp_ready for one cycle → one pop, req_ready=1 the next cycle.
- Simultaneous capture and pop with fifo_count=2 → count stays 2, data order preserved across pointer wrap (≥10 reads total).
- Assert rst_n low one cycle after a read fire → no response after release, resp_count=0. A read of the same address afterwards returns the RAM's current content.
